project_switch_sequencer: RTL and testbench

- Controls which user project in the multi-project harness owns the shared IO/clock resources, and sequences every change of project.
- On a select request it runs a fixed sequence: reset the outgoing project, gate all project clocks, switch the select, then hold the incoming project in reset before releasing it.
- It also routes Wishbone write strobes to the active project only.
- Sits between the Wishbone/LA config logic and the per-project clock-enable, reset and IO mux select.

---
 rtl/project_switch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_project_switch_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/project_switch_sequencer.sv
// Owns the per-project clock enable, reset and IO mux select, and runs the
// drain / gate / hold sequence on every change of active project.
module project_switch_sequencer #(
  parameter int NUM_PROJECTS = 8,
  parameter int SEL_W        = 4,
  parameter int RESET_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_sel_req_valid,
  input  logic [SEL_W-1:0]        i_sel_req_id,
  output logic                    o_sel_req_ready,
  output logic                    o_sel_err,
  output logic [SEL_W-1:0]        o_active_id,
  output logic                    o_busy,
  output logic [NUM_PROJECTS-1:0] o_proj_clk_en,
  output logic [NUM_PROJECTS-1:0] o_proj_reset_n,
  input  logic                    i_wb_strobe,
  output logic [NUM_PROJECTS-1:0] o_proj_wb_update
);

  // state  | meaning
  // BOOT   | project 0 clocked and held in reset after a harness reset
  // ACTIVE | active project runs; select requests accepted
  // DRAIN  | outgoing project clocked and held in reset
  // GATE   | every project clock gated; select switches on the last cycle
  // HOLD   | incoming project clocked and held in reset
  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_ACTIVE = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_GATE   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [SEL_W:0] LP_NUM_PROJ = (SEL_W+1)'(NUM_PROJECTS);
  localparam logic [7:0]     LP_RST_TC   = 8'(RESET_CYCLES - 1);
  localparam logic [7:0]     LP_GAP_TC   = 8'(GAP_CYCLES - 1);

  state_t                  r_state;
  logic [7:0]              r_cnt;
  logic [SEL_W-1:0]        r_active_id;
  logic [SEL_W-1:0]        r_pending;
  logic                    r_boot_wait;
  logic                    r_sel_req_ready;
  logic                    r_sel_err;
  logic                    r_busy;
  logic [NUM_PROJECTS-1:0] r_proj_clk_en;
  logic [NUM_PROJECTS-1:0] r_proj_reset_n;
  logic [NUM_PROJECTS-1:0] r_proj_wb_update;

  state_t                  w_state_nxt;
  logic [7:0]              w_cnt_nxt;
  logic [SEL_W-1:0]        w_active_id_nxt;
  logic [SEL_W-1:0]        w_pending_nxt;
  logic                    w_sel_err_nxt;
  logic                    w_accept;
  logic                    w_id_legal;
  logic                    w_rst_tc;
  logic                    w_gap_tc;
  logic [NUM_PROJECTS-1:0] w_onehot_nxt;
  logic [NUM_PROJECTS-1:0] w_onehot_cur;
  logic [NUM_PROJECTS-1:0] w_clk_en_nxt;
  logic [NUM_PROJECTS-1:0] w_reset_n_nxt;

  assign w_accept   = i_sel_req_valid && r_sel_req_ready;
  assign w_id_legal = ({1'b0, i_sel_req_id} < LP_NUM_PROJ);
  assign w_rst_tc   = (r_cnt == LP_RST_TC);
  assign w_gap_tc   = (r_cnt == LP_GAP_TC);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_active_id_nxt = r_active_id;
    w_pending_nxt   = r_pending;
    w_sel_err_nxt   = 1'b0;
    case (r_state)
      // The reset cycle itself shows reset values, so the boot hold window
      // only starts counting on the first clock after release.
      ST_BOOT: begin
        if (r_boot_wait) begin
          w_cnt_nxt = 8'd0;
        end else if (w_rst_tc) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (w_accept) begin
          if (w_id_legal) begin
            w_pending_nxt = i_sel_req_id;
            w_cnt_nxt     = 8'd0;
            w_state_nxt   = ST_DRAIN;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (w_rst_tc) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_GATE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_GATE: begin
        if (w_gap_tc) begin
          w_active_id_nxt = r_pending;
          w_cnt_nxt       = 8'd0;
          w_state_nxt     = ST_HOLD;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_HOLD: begin
        if (w_rst_tc) begin
          w_cnt_nxt   = 8'd0;
          w_state_nxt = ST_ACTIVE;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: begin
        w_cnt_nxt   = 8'd0;
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    w_onehot_nxt = '0;
    w_onehot_cur = '0;
    for (int i = 0; i < NUM_PROJECTS; i++) begin
      w_onehot_nxt[i] = (w_active_id_nxt == SEL_W'(i));
      w_onehot_cur[i] = (r_active_id == SEL_W'(i));
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_comb begin
    w_clk_en_nxt  = '0;
    w_reset_n_nxt = '0;
    case (w_state_nxt)
      ST_ACTIVE: begin
        w_clk_en_nxt  = w_onehot_nxt;
        w_reset_n_nxt = w_onehot_nxt;
      end
      ST_GATE: begin
        w_clk_en_nxt  = '0;
        w_reset_n_nxt = '0;
      end
      default: begin
        w_clk_en_nxt  = w_onehot_nxt;
        w_reset_n_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state          <= ST_BOOT;
      r_cnt            <= 8'd0;
      r_active_id      <= '0;
      r_pending        <= '0;
      r_boot_wait      <= 1'b1;
      r_sel_req_ready  <= 1'b0;
      r_sel_err        <= 1'b0;
      r_busy           <= 1'b1;
      r_proj_clk_en    <= '0;
      r_proj_reset_n   <= '0;
      r_proj_wb_update <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_cnt            <= w_cnt_nxt;
      r_active_id      <= w_active_id_nxt;
      r_pending        <= w_pending_nxt;
      r_boot_wait      <= 1'b0;
      r_sel_req_ready  <= (w_state_nxt == ST_ACTIVE);
      r_sel_err        <= w_sel_err_nxt;
      r_busy           <= (w_state_nxt != ST_ACTIVE);
      r_proj_clk_en    <= w_clk_en_nxt;
      r_proj_reset_n   <= w_reset_n_nxt;
      // Strobes outside ACTIVE are dropped; an accept in the same cycle still
      // delivers to the outgoing project because r_active_id has not moved.
      r_proj_wb_update <= (r_state == ST_ACTIVE && i_wb_strobe) ? w_onehot_cur : '0;
    end
  end

  assign o_sel_req_ready  = r_sel_req_ready;
  assign o_sel_err        = r_sel_err;
  assign o_active_id      = r_active_id;
  assign o_busy           = r_busy;
  assign o_proj_clk_en    = r_proj_clk_en;
  assign o_proj_reset_n   = r_proj_reset_n;
  assign o_proj_wb_update = r_proj_wb_update;

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Bench for project_switch_sequencer: directed scenarios then random traffic,
// checked every cycle against a schedule-of-frames reference model.
module tb_project_switch_sequencer;
  localparam int N  = 8;
  localparam int SW = 4;
  localparam int R  = 4;
  localparam int G  = 2;

  typedef struct packed {
    logic [7:0] clk_en;
    logic [7:0] rst_n;
    logic       busy;
    logic       ready;
    logic [3:0] id;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sel_req_valid;
  logic [SW-1:0] sel_req_id;
  logic          wb_strobe;
  logic          o_sel_req_ready;
  logic          o_sel_err;
  logic [SW-1:0] o_active_id;
  logic          o_busy;
  logic [N-1:0]  o_proj_clk_en;
  logic [N-1:0]  o_proj_reset_n;
  logic [N-1:0]  o_proj_wb_update;

  always #5 clk = ~clk;

  project_switch_sequencer #(
    .NUM_PROJECTS(N), .SEL_W(SW), .RESET_CYCLES(R), .GAP_CYCLES(G)
  ) dut (
    .i_clk(clk),
    .i_reset_n(reset_n),
    .i_sel_req_valid(sel_req_valid),
    .i_sel_req_id(sel_req_id),
    .o_sel_req_ready(o_sel_req_ready),
    .o_sel_err(o_sel_err),
    .o_active_id(o_active_id),
    .o_busy(o_busy),
    .o_proj_clk_en(o_proj_clk_en),
    .o_proj_reset_n(o_proj_reset_n),
    .i_wb_strobe(wb_strobe),
    .o_proj_wb_update(o_proj_wb_update)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: the expected output frame of the current cycle plus a queue of
  // frames already scheduled by an accepted switch or by a boot.
  frame_t     m_cur;
  frame_t     m_sched[$];
  logic [3:0] m_active;
  logic       m_err;
  logic [7:0] m_upd;

  function automatic logic [7:0] oh(input logic [3:0] id);
    return 8'd1 << id;
  endfunction

  function automatic frame_t mk(input logic [7:0] ce, input logic [7:0] rn,
                                input logic b, input logic rd, input logic [3:0] id);
    frame_t f;
    f.clk_en = ce;
    f.rst_n  = rn;
    f.busy   = b;
    f.ready  = rd;
    f.id     = id;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(output logic acc);
    acc = 1'b0;
    if (!reset_n) begin
      m_cur    = mk(8'h00, 8'h00, 1'b1, 1'b0, 4'd0);
      m_active = 4'd0;
      m_err    = 1'b0;
      m_upd    = 8'h00;
      m_sched.delete();
      for (int i = 0; i < R; i++) m_sched.push_back(mk(oh(4'd0), 8'h00, 1'b1, 1'b0, 4'd0));
    end else begin
      m_upd = (m_cur.ready && wb_strobe) ? oh(m_cur.id) : 8'h00;
      m_err = 1'b0;
      if (m_cur.ready && sel_req_valid) begin
        acc = 1'b1;
        if (sel_req_id < N) begin
          for (int i = 0; i < R; i++) m_sched.push_back(mk(oh(m_active), 8'h00, 1'b1, 1'b0, m_active));
          for (int i = 0; i < G; i++) m_sched.push_back(mk(8'h00, 8'h00, 1'b1, 1'b0, m_active));
          m_active = sel_req_id;
          for (int i = 0; i < R; i++) m_sched.push_back(mk(oh(m_active), 8'h00, 1'b1, 1'b0, m_active));
        end else begin
          m_err = 1'b1;
        end
      end
      if (m_sched.size() > 0) m_cur = m_sched.pop_front();
      else                    m_cur = mk(oh(m_active), oh(m_active), 1'b0, 1'b1, m_active);
    end
  endtask

  task automatic step();
    logic acc;
    model_edge(acc);
    @(posedge clk);
    #1;
    chk("active_id",  32'(o_active_id),      32'(m_cur.id));
    chk("clk_en",     32'(o_proj_clk_en),    32'(m_cur.clk_en));
    chk("reset_n",    32'(o_proj_reset_n),   32'(m_cur.rst_n));
    chk("busy",       32'(o_busy),           32'(m_cur.busy));
    chk("ready",      32'(o_sel_req_ready),  32'(m_cur.ready));
    chk("sel_err",    32'(o_sel_err),        32'(m_err));
    chk("wb_update",  32'(o_proj_wb_update), 32'(m_upd));
    chk("clk_en_onehot0", 32'($onehot0(o_proj_clk_en)), 1);
    chk("reset_n_only_active",
        32'((o_proj_reset_n == 8'h00) || (!o_busy && $onehot(o_proj_reset_n))), 1);
    if (acc) sel_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && o_busy; i++) step();
    chk("wait_idle_timeout", 32'(o_busy), 0);
  endtask

  task automatic request(input logic [3:0] id);
    sel_req_valid = 1'b1;
    sel_req_id    = id;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_boot;
    int k;
    reset_n       = 1'b0;
    sel_req_valid = 1'b0;
    sel_req_id    = '0;
    wb_strobe     = 1'b0;
    m_cur         = mk(8'h00, 8'h00, 1'b1, 1'b0, 4'd0);
    m_active      = 4'd0;
    m_err         = 1'b0;
    m_upd         = 8'h00;
    repeat (3) step();

    // boot: project 0 clocked in reset for R cycles, then active
    reset_n = 1'b1;
    n_boot  = 0;
    for (int i = 0; i < 20 && o_busy; i++) begin
      step();
      if (o_busy && o_proj_clk_en == 8'h01 && o_proj_reset_n == 8'h00) n_boot++;
    end
    chk("boot_len", n_boot, R);
    chk("boot_active_rst", 32'(o_proj_reset_n), 32'h01);

    // switch 0 -> 5, accept-to-release latency
    request(4'd5);
    k = 1;
    for (int i = 0; i < 30 && o_proj_reset_n != 8'h20; i++) begin
      step();
      k++;
    end
    chk("accept_to_release", k, 2 * R + G + 1);
    chk("switch5_id", 32'(o_active_id), 5);

    // illegal id
    request(4'd9);
    chk("err_pulse", 32'(o_sel_err), 1);
    step();
    chk("err_cleared", 32'(o_sel_err), 0);
    chk("err_id_kept", 32'(o_active_id), 5);

    // re-reset of 5 while a request for 3 is held pending
    request(4'd5);
    sel_req_valid = 1'b1;
    sel_req_id    = 4'd3;
    wait_idle();
    chk("held_still_valid", 32'(sel_req_valid), 1);
    chk("rereset_id", 32'(o_active_id), 5);
    step();
    wait_idle();
    chk("held_final_id", 32'(o_active_id), 3);

    // wishbone routing on project 2, then a strobe dropped in GATE
    request(4'd2);
    wait_idle();
    wb_strobe = 1'b1;
    step();
    wb_strobe = 1'b0;
    chk("wb_upd_p2", 32'(o_proj_wb_update), 32'h04);
    wb_strobe = 1'b1;
    request(4'd4);
    wb_strobe = 1'b0;
    chk("wb_upd_on_accept", 32'(o_proj_wb_update), 32'h04);
    repeat (R) step();
    wb_strobe = 1'b1;
    step();
    wb_strobe = 1'b0;
    chk("wb_upd_gate", 32'(o_proj_wb_update), 0);
    wait_idle();

    // reset mid-GATE during 0 -> 6
    request(4'd0);
    wait_idle();
    request(4'd6);
    repeat (R) step();
    chk("in_gate_clk", 32'(o_proj_clk_en), 0);
    reset_n = 1'b0;
    step();
    chk("rst_id", 32'(o_active_id), 0);
    chk("rst_busy", 32'(o_busy), 1);
    reset_n = 1'b1;
    wait_idle();
    chk("reboot_id", 32'(o_active_id), 0);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      if (!sel_req_valid && $urandom_range(0, 7) == 0) begin
        sel_req_valid = 1'b1;
        sel_req_id = ($urandom_range(0, 3) == 0) ? 4'(8 + $urandom_range(0, 7))
                                                 : 4'($urandom_range(0, 7));
      end
      wb_strobe = 1'($urandom_range(0, 1));
      reset_n   = ($urandom_range(0, 149) != 0);
      step();
    end
    reset_n       = 1'b1;
    wb_strobe     = 1'b0;
    sel_req_valid = 1'b0;
    step();
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
